dmem_responder: RTL

Data-memory responder for the 3-stage RISC-V core; it is the slave end of the core's dmem read/write request interface. It accepts level-held read requests from execute and write requests from writeback, and services them one at a time after a programmable number of wait states. It returns each result with a one-cycle valid pulse. It holds a word-organised RAM with byte-strobed writes.

---
 rtl/dmem_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the 3-stage RISC-V core.
// It serves level-held read and write requests one at a time, after LATENCY wait cycles.
// Each completion is returned as a one-cycle valid pulse.
// Optional feature macro: DMEM_RANGE_CHECK_EN. When it is defined, byte addresses at or
// above DEPTH*4 raise a fault instead of wrapping.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_read_ready,
    input  logic [31:0] dmem_read_address,
    input  logic        dmem_write_ready,
    input  logic [31:0] dmem_write_address,
    input  logic [31:0] dmem_write_data,
    input  logic [3:0]  dmem_write_byte,
    output logic [31:0] dmem_read_data,
    output logic        dmem_read_valid,
    output logic        dmem_write_valid,
    output logic        dmem_busy,
    output logic        dmem_access_fault
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               accept_wr;
    logic               accept_rd;
    logic               do_op;
    logic [CNT_W-1:0]   counter;
    logic               op_write;
    logic [ADDR_W-1:0]  op_idx;
    logic [31:0]        op_data;
    logic [3:0]         op_strb;
    logic               op_oor;
    logic               oor_wr_in;
    logic               oor_rd_in;
    logic [31:0]        mem [DEPTH];

`ifdef DMEM_RANGE_CHECK_EN
    assign oor_wr_in = (dmem_write_address[31:ADDR_W+2] != '0);
    assign oor_rd_in = (dmem_read_address[31:ADDR_W+2] != '0);
`else
    assign oor_wr_in = 1'b0;
    assign oor_rd_in = 1'b0;
`endif

    // Byte-lane bits and, without the range check, the upper address bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dmem_read_address[1:0], dmem_read_address[31:ADDR_W+2],
                                dmem_write_address[1:0], dmem_write_address[31:ADDR_W+2]};

    assign dmem_busy = (state != IDLE);

    // Next-state logic: the write wins in IDLE because it belongs to the older instruction.
    always_comb begin
        state_next = state;
        accept_wr  = 1'b0;
        accept_rd  = 1'b0;
        do_op      = 1'b0;
        case (state)
            IDLE: begin
                if (dmem_write_ready) begin
                    accept_wr  = 1'b1;
                    state_next = WAIT;
                end else if (dmem_read_ready) begin
                    accept_rd  = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (counter == '0) begin
                    do_op      = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Latch the accepted request and count down the wait states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter  <= '0;
            op_write <= 1'b0;
            op_idx   <= '0;
            op_data  <= '0;
            op_strb  <= '0;
            op_oor   <= 1'b0;
        end else if (accept_wr) begin
            counter  <= CNT_LOAD;
            op_write <= 1'b1;
            op_idx   <= dmem_write_address[ADDR_W+1:2];
            op_data  <= dmem_write_data;
            op_strb  <= dmem_write_byte;
            op_oor   <= oor_wr_in;
        end else if (accept_rd) begin
            counter  <= CNT_LOAD;
            op_write <= 1'b0;
            op_idx   <= dmem_read_address[ADDR_W+1:2];
            op_oor   <= oor_rd_in;
        end else if (state == WAIT && counter != '0) begin
            counter  <= counter - 1'b1;
        end
    end

    // Word RAM with byte strobes. The RAM is never reset, so an aborted write leaves no trace.
    always_ff @(posedge clk) begin
        if (do_op && op_write && !op_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (op_strb[b]) mem[op_idx][8*b +: 8] <= op_data[8*b +: 8];
            end
        end
    end

    // Completion pulses. Read data holds until the next read completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem_read_valid   <= 1'b0;
            dmem_write_valid  <= 1'b0;
            dmem_access_fault <= 1'b0;
            dmem_read_data    <= '0;
        end else begin
            dmem_read_valid   <= do_op & ~op_write;
            dmem_write_valid  <= do_op & op_write;
            dmem_access_fault <= do_op & op_oor;
            if (do_op && !op_write) dmem_read_data <= op_oor ? 32'h0 : mem[op_idx];
        end
    end

endmodule
